mult_seq: RTL

//  Multi-cycle 16x16 shift-add multiplier controller. Owns one twosCompUnit instance and sequences it.
//  - Iterations: ADD, Oper=2'b00.
//  - Optional signed correction: subtracts.

---
 rtl/mult_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mult_seq.sv
// Multi-cycle shift-add multiplier sequencing one twosCompUnit adder.
// Define MULT_SIGNED_EN to add the sign_op port and two's-complement correction states.

module twosCompUnit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic             sign_i,
   input  logic [1:0]       oper_i,
   output logic [WIDTH-1:0] out_o,
   output logic             ofl_o
);
   logic [WIDTH:0] sum;

   always_comb begin
      sum   = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
      out_o = '0;
      ofl_o = 1'b0;
      case (oper_i)
         2'b00: begin
            out_o = sum[WIDTH-1:0];
            // signed mode reports two's-complement overflow, unsigned mode the carry
            ofl_o = sign_i ? ((a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]))
                           : sum[WIDTH];
         end
         2'b01:   out_o = a_i & b_i;
         2'b10:   out_o = a_i | b_i;
         default: out_o = a_i ^ b_i;
      endcase
   end
endmodule

module mult_seq #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
`ifdef MULT_SIGNED_EN
   input  logic               sign_op,
`endif
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
`ifdef MULT_SIGNED_EN
      S_CORR1,
      S_CORR2,
`endif
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d, phi_q, phi_d, plo_q, plo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
`ifdef MULT_SIGNED_EN
   logic               sign_q, sign_d;
   logic [WIDTH-1:0]   mpl_q, mpl_d;
`endif
   logic [WIDTH-1:0]   u_b, u_out;
   logic               u_cin, u_ofl;

   twosCompUnit #(.WIDTH(WIDTH)) u_add (
      .a_i   (phi_q),
      .b_i   (u_b),
      .cin_i (u_cin),
      .sign_i(1'b0),
      .oper_i(2'b00),
      .out_o (u_out),
      .ofl_o (u_ofl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
`ifdef MULT_SIGNED_EN
         sign_q  <= 1'b0;
         mpl_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
`ifdef MULT_SIGNED_EN
         sign_q  <= sign_d;
         mpl_q   <= mpl_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
`ifdef MULT_SIGNED_EN
      sign_d  = sign_q;
      mpl_d   = mpl_q;
`endif
      u_b     = '0;
      u_cin   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d     = mcand;
               phi_d   = '0;
               plo_d   = mplier;
               cnt_d   = '0;
`ifdef MULT_SIGNED_EN
               sign_d  = sign_op;
               mpl_d   = mplier;
`endif
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            u_b            = plo_q[0] ? m_q : '0;
            {phi_d, plo_d} = {u_ofl, u_out, plo_q[WIDTH-1:1]};
            cnt_d          = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef MULT_SIGNED_EN
               if (sign_q) begin
                  state_d = S_CORR1;
               end else begin
                  state_d = S_DONE;
                  prod_d  = {u_ofl, u_out, plo_q[WIDTH-1:1]};
               end
`else
               state_d = S_DONE;
               prod_d  = {u_ofl, u_out, plo_q[WIDTH-1:1]};
`endif
            end
         end
`ifdef MULT_SIGNED_EN
         // subtract via A + ~X + 1; the carry-out is meaningless here and dropped
         S_CORR1: begin
            u_b     = ~(m_q[WIDTH-1] ? mpl_q : '0);
            u_cin   = 1'b1;
            phi_d   = u_out;
            state_d = S_CORR2;
         end
         S_CORR2: begin
            u_b     = ~(mpl_q[WIDTH-1] ? m_q : '0);
            u_cin   = 1'b1;
            phi_d   = u_out;
            prod_d  = {u_out, plo_q};
            state_d = S_DONE;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign product = prod_q;
endmodule
